// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: FSM states, pattern mode encodings and the Fibonacci LFSR tap table
// shared by the RAM self-test controller.
package ram_bist_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [1:0] MODE_ADDR = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;

    // Maximal-length feedback taps, indexed by register width; bit k-1 set for tap k.
    localparam logic [31:0] LFSR_TAPS [1:32] = '{
        32'h0000_0001, 32'h0000_0003, 32'h0000_0006, 32'h0000_000C,
        32'h0000_0014, 32'h0000_0030, 32'h0000_0060, 32'h0000_00B8,
        32'h0000_0110, 32'h0000_0240, 32'h0000_0500, 32'h0000_0829,
        32'h0000_100D, 32'h0000_2015, 32'h0000_6000, 32'h0000_D008,
        32'h0001_2000, 32'h0002_0400, 32'h0004_0023, 32'h0009_0000,
        32'h0014_0000, 32'h0030_0000, 32'h0042_0000, 32'h00E1_0000,
        32'h0120_0000, 32'h0200_0023, 32'h0400_0013, 32'h0900_0000,
        32'h1400_0000, 32'h2000_0029, 32'h4800_0000, 32'h8020_0003
    };

    // Caller truncates the result to its own width; bits above it are shifted out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w);
        return {s[30:0], ^(s & LFSR_TAPS[w])};
    endfunction

endpackage

// File: rtl/ram_bist_ctrl_ram.sv
// ram_sp_sync: behavioural single-port synchronous RAM with an RD_LAT-stage read
// output register; contents are never cleared, only the output stages reset.
module ram_sp_sync
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk_50M,
    input  logic              RST_N,
    input  logic              wren,
    input  logic              rden,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rq  [RD_LAT];

    always_ff @(posedge clk_50M)
        if (wren) mem[addr] <= wdata;

    always_ff @(posedge clk_50M or negedge RST_N)
        if (!RST_N) begin
            for (int i = 0; i < RD_LAT; i++) rq[i] <= '0;
        end else begin
            if (rden) rq[0] <= mem[addr];
            for (int i = 1; i < RD_LAT; i++) rq[i] <= rq[i-1];
        end

    assign rdata = rq[RD_LAT-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read-back self-test of an embedded RAM with pass/fail, error count
// and first failing address. Define RAM_BIST_LFSR_EN to build the LFSR pattern (mode 2).
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk_50M,
    input  logic              RST_N,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              inj_en,
    input  logic [ADDR_W-1:0] inj_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wrdata,
    output logic [DATA_W-1:0] rddata,
    output logic              wren,
    output logic              rden
);
    state_t            state, state_nx;
    logic [1:0]        mode_q, drain_cnt;
    logic              inj_en_q, done_old, accept, last, mism;
    logic [ADDR_W-1:0] inj_addr_q;
    logic [DATA_W-1:0] pat;
    logic [RD_LAT-1:0] pv;
    logic [DATA_W-1:0] pe [RD_LAT];
    logic [ADDR_W-1:0] pa [RD_LAT];

    // The first DONE cycle never accepts start, so a held start cannot skip DONE.
    assign accept = start && (state == IDLE || (state == DONE && done_old));
    assign last   = &address;
    assign busy   = state inside {WRITE, READ, DRAIN};
    assign done   = state == DONE;
    assign pass   = done && err_cnt == '0;
    assign wren   = state == WRITE;
    assign rden   = state == READ;
    assign wrdata = wren ? pat ^ DATA_W'(inj_en_q && address == inj_addr_q) : '0;
    assign mism   = pv[RD_LAT-1] && rddata != pe[RD_LAT-1];

`ifdef RAM_BIST_LFSR_EN
    logic [DATA_W-1:0] lfsr;

    // Reseeded for the read phase so it regenerates the written sequence.
    always_ff @(posedge clk_50M or negedge RST_N)
        if (!RST_N)                          lfsr <= '1;
        else if (accept || (wren && last))   lfsr <= '1;
        else if (wren || rden)               lfsr <= DATA_W'(lfsr_step(32'(lfsr), DATA_W));

    assign pat = mode_q == MODE_LFSR ? lfsr :
                 mode_q == MODE_INV  ? ~DATA_W'(address) : DATA_W'(address);
`else
    assign pat = mode_q == MODE_INV ? ~DATA_W'(address) : DATA_W'(address);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = accept ? WRITE : state;
            WRITE:      state_nx = last ? READ : WRITE;
            READ:       state_nx = last ? DRAIN : READ;
            DRAIN:      state_nx = drain_cnt == 2'(RD_LAT - 1) ? DONE : DRAIN;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge RST_N)
        if (!RST_N) begin
            state          <= IDLE;
            address        <= '0;
            mode_q         <= MODE_ADDR;
            inj_en_q       <= 1'b0;
            inj_addr_q     <= '0;
            done_old       <= 1'b0;
            drain_cnt      <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            state     <= state_nx;
            done_old  <= done;
            drain_cnt <= state == DRAIN ? drain_cnt + 2'd1 : 2'd0;
            address   <= (wren || rden) ? address + ADDR_W'(1) : '0;
            if (accept) begin
                mode_q         <= mode;
                inj_en_q       <= inj_en;
                inj_addr_q     <= inj_addr;
                err_cnt        <= '0;
                first_err_addr <= '0;
            end else if (mism) begin
                if (err_cnt == '0) first_err_addr <= pa[RD_LAT-1];
                if (~&err_cnt) err_cnt <= err_cnt + (ADDR_W+1)'(1);
            end
        end

    // Expected word and address travel alongside the RAM read latency.
    always_ff @(posedge clk_50M or negedge RST_N)
        if (!RST_N) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pe[i] <= '0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= rden;
            pe[0] <= pat;
            pa[0] <= address;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pa[i] <= pa[i-1];
            end
        end

    ram_sp_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_ram (
        .clk_50M (clk_50M),
        .RST_N   (RST_N),
        .wren    (wren),
        .rden    (rden),
        .addr    (address),
        .wdata   (wrdata),
        .rdata   (rddata)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: randomized self-checking bench for ram_bist_ctrl against a
// cycle-indexed behavioural model; honours RAM_BIST_LFSR_EN for the mode-2 checks.
module tb_ram_bist_ctrl;
    localparam int D = 32, L = 1, T = 2*D + L;

    logic       clk_50M = 1'b0;
    logic       RST_N = 1'b1;
    logic       start = 1'b0, inj_en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [4:0] inj_addr = 5'd0;
    logic       busy, done, pass, wren, rden;
    logic [5:0] err_cnt;
    logic [4:0] first_err_addr, address;
    logic [7:0] wrdata, rddata;

    logic       b_start = 1'b0;
    logic       b_busy, b_done, b_pass, b_wren, b_rden;
    logic [3:0] b_err, b_wd, b_rd;
    logic [2:0] b_fea, b_addr;

    int tests = 0, fails = 0;
    int t = 0, m_ia = 0, b_wcnt = 0;
    logic [1:0] m_mode = 2'd0;
    logic       m_inj = 1'b0;
    logic [7:0] mem [D];
    logic [7:0] lf [D];
    logic [7:0] wlog [D];
    logic [3:0] b_wlog [8];
    bit chk_en = 1'b0;

    always #10 clk_50M = ~clk_50M;

    ram_bist_ctrl dut (
        .clk_50M(clk_50M), .RST_N(RST_N), .start(start), .mode(mode), .inj_en(inj_en),
        .inj_addr(inj_addr), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .address(address), .wrdata(wrdata),
        .rddata(rddata), .wren(wren), .rden(rden)
    );

    ram_bist_ctrl #(.DATA_W(4), .ADDR_W(3), .RD_LAT(2)) dut_b (
        .clk_50M(clk_50M), .RST_N(RST_N), .start(b_start), .mode(2'd0), .inj_en(1'b0),
        .inj_addr(3'd0), .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
        .first_err_addr(b_fea), .address(b_addr), .wrdata(b_wd),
        .rddata(b_rd), .wren(b_wren), .rden(b_rden)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        if (m_mode == 2'd1) return ~8'(a);
`ifdef RAM_BIST_LFSR_EN
        if (m_mode == 2'd2) return lf[a];
`endif
        return 8'(a);
    endfunction

    // Model: t counts cycles since the accepting edge (0 = idle since reset).
    always @(posedge clk_50M or negedge RST_N) begin
        if (!RST_N) t = 0;
        else begin
            if (t >= 1 && t <= D) mem[t-1] = pat(t-1) ^ 8'(m_inj && m_ia == t-1);
            if (start && (t == 0 || t >= T + 2)) begin
                t = 1; m_mode = mode; m_inj = inj_en; m_ia = int'(inj_addr);
            end else if (t > 0 && t < 1000000) t++;
        end
    end

    always @(negedge clk_50M) if (chk_en) begin : cmp
        int ne, fe, lim, ea;
        bit wr, rd, dn;
        ne = 0; fe = 0; lim = t - D - 1 - L;
        for (int a = 0; a < D; a++)
            if (a < lim && mem[a] != pat(a)) begin
                if (ne == 0) fe = a;
                ne++;
            end
        wr = t >= 1 && t <= D;
        rd = t > D && t <= 2*D;
        dn = t > T;
        ea = wr ? t - 1 : rd ? t - 1 - D : 0;
        chk("busy", busy, t >= 1 && !dn);
        chk("done", done, dn);
        chk("pass", pass, dn && ne == 0);
        chk("err_cnt", err_cnt, ne);
        chk("first_err_addr", first_err_addr, fe);
        chk("address", address, ea);
        chk("wren", wren, wr);
        chk("rden", rden, rd);
        if (wr) begin
            chk("wrdata", wrdata, pat(ea) ^ 8'(m_inj && m_ia == ea));
            wlog[ea] = wrdata;
        end else if (t == 0) chk("wrdata_idle", wrdata, 0);
        if (t > D + L && t <= 2*D + L) chk("rddata", rddata, mem[t-D-1-L]);
    end

    always @(negedge clk_50M) if (b_wren) begin
        b_wlog[b_addr] = b_wd;
        b_wcnt++;
    end

    task automatic run_test(input logic [1:0] md, input logic ie, input logic [4:0] ia, output int n);
        repeat (2) @(negedge clk_50M);
        start = 1'b1; mode = md; inj_en = ie; inj_addr = ia;
        @(posedge clk_50M);
        #1 start = 1'b0; mode = 2'($urandom); inj_en = 1'($urandom); inj_addr = 5'($urandom);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk_50M);
            #1 n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] md;
        logic ie;
        logic [4:0] ia;
        lf[0] = 8'hFF;
        for (int i = 1; i < D; i++)
            lf[i] = {lf[i-1][6:0], lf[i-1][7] ^ lf[i-1][5] ^ lf[i-1][4] ^ lf[i-1][3]};
        #1 RST_N = 1'b0;
        #5 chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_first", first_err_addr, 0);
        chk("rst_addr", address, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_strobes", {wren, rden}, 0);
        repeat (2) @(negedge clk_50M);
        #2 RST_N = 1'b1;

        // Narrow instance: RD_LAT=2, ADDR_W=3, DATA_W=4.
        @(negedge clk_50M);
        b_start = 1'b1;
        @(posedge clk_50M);
        #1 b_start = 1'b0;
        n = 0;
        while (!b_done && n < 100) begin
            @(posedge clk_50M);
            #1 n++;
        end
        chk("b_done_edge", n, 18);
        chk("b_pass", b_pass, 1);
        chk("b_err", b_err, 0);
        chk("b_wcnt", b_wcnt, 8);
        for (int i = 0; i < 8; i++) chk("b_wdata", b_wlog[i], i);

        run_test(2'd0, 1'b0, 5'd0, n);
        chk("t1_edges", n, 65);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_w31", wlog[31], 8'd31);

        run_test(2'd1, 1'b1, 5'd5, n);
        chk("t2_edges", n, 65);
        chk("t2_w5", wlog[5], 8'hFB);
        chk("t2_w6", wlog[6], 8'hF9);
        chk("t2_pass", pass, 0);
        chk("t2_err", err_cnt, 1);
        chk("t2_first", first_err_addr, 5);

        run_test(2'd2, 1'b0, 5'd0, n);
        chk("t3_pass", pass, 1);
`ifdef RAM_BIST_LFSR_EN
        chk("t3_w0", wlog[0], 8'hFF);
        chk("t3_w1", wlog[1], 8'hFE);
        chk("t3_w2", wlog[2], 8'hFC);
`else
        chk("t3_w0", wlog[0], 8'h00);
        chk("t3_w1", wlog[1], 8'h01);
        chk("t3_w2", wlog[2], 8'h02);
`endif

        // Abort mid-READ.
        repeat (2) @(negedge clk_50M);
        start = 1'b1; mode = 2'd1; inj_en = 1'b0;
        @(posedge clk_50M);
        #1 start = 1'b0;
        repeat (40) @(posedge clk_50M);
        #3 RST_N = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rden", rden, 0);
        chk("abort_addr", address, 0);
        chk("abort_done", done, 0);
        chk("abort_rddata", rddata, 0);
        @(negedge clk_50M);
        #3 RST_N = 1'b1;
        run_test(2'd0, 1'b0, 5'd0, n);
        chk("after_abort_edges", n, 65);
        chk("after_abort_pass", pass, 1);

        repeat (6) begin
            md = 2'($urandom_range(0, 3));
            ie = 1'($urandom_range(0, 1));
            ia = 5'($urandom_range(0, 31));
            run_test(md, ie, ia, n);
            chk("rand_edges", n, 65);
            chk("rand_err", err_cnt, ie);
            chk("rand_pass", pass, !ie);
            if (ie) chk("rand_first", first_err_addr, ia);
            repeat ($urandom_range(0, 4)) @(negedge clk_50M);
        end

        // start held high across a whole test and into DONE.
        repeat (2) @(negedge clk_50M);
        start = 1'b1; mode = 2'd0; inj_en = 1'b0;
        @(posedge clk_50M);
        #1 n = 0;
        while (!done && n < 200) begin
            @(posedge clk_50M);
            #1 n++;
        end
        chk("hold_edges", n, 65);
        n = 1;
        while (done && n < 10) begin
            @(posedge clk_50M);
            #1;
            if (done) n++;
        end
        chk("hold_done_cycles", n, 2);
        chk("hold_busy", busy, 1);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk_50M);
            #1 n++;
        end
        chk("hold_second_edges", n, 65);
        @(negedge clk_50M);
        start = 1'b0;

        repeat (3) @(negedge clk_50M);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
